// File: rtl/wb_commit_grf_if.sv
// Writeback/register-file bus: W-stage commit inputs, D-stage read ports,
// forward-unit outputs and the commit trace seen by the verification bench.
interface wb_commit_grf_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic [1:0]        wd_sel;
    logic              rf_en;
    logic [DATA_W-1:0] fw;
    logic [DATA_W-1:0] dmrd;
    logic [4:0]        a3;
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] cp0_out;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] wd;
    logic              we_eff;
    logic              trace_valid;
    logic [DATA_W-1:0] trace_pc;
    logic [4:0]        trace_reg;
    logic [DATA_W-1:0] trace_data;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output wd_sel, rf_en, fw, dmrd, a3, pc8, cp0_out, ra1, ra2,
        input  rd1, rd2, wd, we_eff, trace_valid, trace_pc, trace_reg, trace_data, retire_cnt
    );

    modport slave (
        input  wd_sel, rf_en, fw, dmrd, a3, pc8, cp0_out, ra1, ra2,
        output rd1, rd2, wd, we_eff, trace_valid, trace_pc, trace_reg, trace_data, retire_cnt
    );
endinterface

// File: rtl/wb_commit_grf.sv
// Writeback stage: picks the writeback value, commits it to the 32-entry GRF,
// serves the two D-stage read ports (optionally with W->D write-through) and
// keeps a one-cycle-late commit trace plus a retire counter.
module wb_commit_grf #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    wb_commit_grf_if.slave  bus
);

    logic [DATA_W-1:0] grf [32];
    logic [DATA_W-1:0] wd_mux;
    logic              we;

    // Writeback source select; default arm keeps an unknown select from inferring a latch
    always_comb begin
        wd_mux = bus.fw;
        case (bus.wd_sel)
            2'd0:    wd_mux = bus.fw;
            2'd1:    wd_mux = bus.dmrd;
            2'd2:    wd_mux = bus.pc8;
            2'd3:    wd_mux = bus.cp0_out;
            default: wd_mux = bus.fw;
        endcase
    end

    // A write to $0 is a bubble: no commit, no trace, no count
    always_comb begin
        we = bus.rf_en && (bus.a3 != 5'd0);
    end

    assign bus.wd     = wd_mux;
    assign bus.we_eff = we;

    // Read port 1: $0 is hardwired zero, optional same-cycle write-through
    always_comb begin
        if (bus.ra1 == 5'd0)
            bus.rd1 = '0;
        else if (BYPASS && we && (bus.ra1 == bus.a3))
            bus.rd1 = wd_mux;
        else
            bus.rd1 = grf[bus.ra1];
    end

    // Read port 2: identical rule to port 1
    always_comb begin
        if (bus.ra2 == 5'd0)
            bus.rd2 = '0;
        else if (BYPASS && we && (bus.ra2 == bus.a3))
            bus.rd2 = wd_mux;
        else
            bus.rd2 = grf[bus.ra2];
    end

    // Register file commit; reset clears every entry and wins over a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                grf[i] <= '0;
        end else if (we) begin
            grf[bus.a3] <= wd_mux;
        end
    end

    // Commit trace and retire counter; trace fields hold when nothing commits
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.trace_valid <= 1'b0;
            bus.trace_pc    <= '0;
            bus.trace_reg   <= 5'd0;
            bus.trace_data  <= '0;
            bus.retire_cnt  <= '0;
        end else begin
            bus.trace_valid <= we;
            if (we) begin
                bus.trace_pc   <= bus.pc8 - DATA_W'(8);
                bus.trace_reg  <= bus.a3;
                bus.trace_data <= wd_mux;
                bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_grf.sv
// Directed bench for wb_commit_grf: three instances share one stimulus stream
// (write-through, registered-read, and a 4-bit retire counter variant).
module tb_wb_commit_grf;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    wb_commit_grf_if #(.DATA_W(32), .CNT_W(32)) bus_main ();
    wb_commit_grf_if #(.DATA_W(32), .CNT_W(32)) bus_nb ();
    wb_commit_grf_if #(.DATA_W(32), .CNT_W(4))  bus_c4 ();

    wb_commit_grf #(.DATA_W(32), .BYPASS(1'b1), .CNT_W(32)) dut_main (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_main)
    );

    wb_commit_grf #(.DATA_W(32), .BYPASS(1'b0), .CNT_W(32)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    wb_commit_grf #(.DATA_W(32), .BYPASS(1'b1), .CNT_W(4)) dut_c4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_c4)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic en, input logic [31:0] fw,
                                 input logic [31:0] dmrd, input logic [4:0] a3, input logic [31:0] pc8,
                                 input logic [31:0] cp0, input logic [4:0] ra1, input logic [4:0] ra2);
        bus_main.wd_sel = sel;  bus_nb.wd_sel = sel;  bus_c4.wd_sel = sel;
        bus_main.rf_en  = en;   bus_nb.rf_en  = en;   bus_c4.rf_en  = en;
        bus_main.fw     = fw;   bus_nb.fw     = fw;   bus_c4.fw     = fw;
        bus_main.dmrd   = dmrd; bus_nb.dmrd   = dmrd; bus_c4.dmrd   = dmrd;
        bus_main.a3     = a3;   bus_nb.a3     = a3;   bus_c4.a3     = a3;
        bus_main.pc8    = pc8;  bus_nb.pc8    = pc8;  bus_c4.pc8    = pc8;
        bus_main.cp0_out = cp0; bus_nb.cp0_out = cp0; bus_c4.cp0_out = cp0;
        bus_main.ra1    = ra1;  bus_nb.ra1    = ra1;  bus_c4.ra1    = ra1;
        bus_main.ra2    = ra2;  bus_nb.ra2    = ra2;  bus_c4.ra2    = ra2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31);
        checkOutput("rst_valid", 32'(bus_main.trace_valid), 32'd0);
        checkOutput("rst_cnt", bus_main.retire_cnt, 32'd0);
        checkOutput("rst_pc", bus_main.trace_pc, 32'd0);
        checkOutput("rst_rd1", bus_main.rd1, 32'd0);
        checkOutput("rst_rd2", bus_main.rd2, 32'd0);

        // Basic commit of fw to $5
        applyStimulus(2'd0, 1'b1, 32'h1234, 32'd0, 5'd5, 32'h3008, 32'd0, 5'd0, 5'd0);
        checkOutput("t1_wd", bus_main.wd, 32'h1234);
        checkOutput("t1_we", 32'(bus_main.we_eff), 32'd1);
        tick();
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        checkOutput("t1_valid", 32'(bus_main.trace_valid), 32'd1);
        checkOutput("t1_pc", bus_main.trace_pc, 32'h3000);
        checkOutput("t1_reg", 32'(bus_main.trace_reg), 32'd5);
        checkOutput("t1_data", bus_main.trace_data, 32'h1234);
        checkOutput("t1_cnt", bus_main.retire_cnt, 32'd1);
        checkOutput("t1_rd1", bus_main.rd1, 32'h1234);
        checkOutput("t1_rd2", bus_main.rd2, 32'd0);

        // Write-through versus registered read on $7
        applyStimulus(2'd1, 1'b1, 32'd0, 32'hDEAD, 5'd7, 32'h3010, 32'd0, 5'd7, 5'd7);
        checkOutput("t2_byp_rd1", bus_main.rd1, 32'hDEAD);
        checkOutput("t2_byp_rd2", bus_main.rd2, 32'hDEAD);
        checkOutput("t2_nb_rd1", bus_nb.rd1, 32'd0);
        checkOutput("t2_nb_rd2", bus_nb.rd2, 32'd0);
        tick();
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7);
        checkOutput("t2_nb_rd1_next", bus_nb.rd1, 32'hDEAD);
        checkOutput("t2_nb_rd2_next", bus_nb.rd2, 32'hDEAD);
        checkOutput("t2_cnt", bus_main.retire_cnt, 32'd2);

        // Write to $0 is a bubble
        applyStimulus(2'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'h3020, 32'd0, 5'd0, 5'd7);
        checkOutput("t3_we", 32'(bus_main.we_eff), 32'd0);
        checkOutput("t3_rd1", bus_main.rd1, 32'd0);
        checkOutput("t3_rd2", bus_main.rd2, 32'hDEAD);
        tick();
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        checkOutput("t3_valid", 32'(bus_main.trace_valid), 32'd0);
        checkOutput("t3_cnt", bus_main.retire_cnt, 32'd2);
        checkOutput("t3_hold_reg", 32'(bus_main.trace_reg), 32'd7);
        checkOutput("t3_hold_data", bus_main.trace_data, 32'hDEAD);
        checkOutput("t3_hold_pc", bus_main.trace_pc, 32'h3008);

        // Writeback source sweep, then jal-style commit of pc8 into $31
        for (int s = 0; s < 4; s++) begin
            logic [31:0] exp_wd;
            case (s)
                0:       exp_wd = 32'd1;
                1:       exp_wd = 32'd2;
                2:       exp_wd = 32'h3010;
                default: exp_wd = 32'd4;
            endcase
            applyStimulus(2'(s), 1'b0, 32'd1, 32'd2, 5'd31, 32'h3010, 32'd4, 5'd0, 5'd0);
            checkOutput($sformatf("t4_wd_sel%0d", s), bus_main.wd, exp_wd);
        end
        applyStimulus(2'd2, 1'b1, 32'd1, 32'd2, 5'd31, 32'h3010, 32'd4, 5'd0, 5'd0);
        tick();
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd0);
        checkOutput("t4_rd31", bus_main.rd1, 32'h3010);
        checkOutput("t4_nb_rd31", bus_nb.rd1, 32'h3010);
        checkOutput("t4_reg", 32'(bus_main.trace_reg), 32'd31);
        checkOutput("t4_pc", bus_main.trace_pc, 32'h3008);
        checkOutput("t4_cnt", bus_main.retire_cnt, 32'd3);

        // Reset overrides a simultaneous write
        applyStimulus(2'd0, 1'b1, 32'hAA, 32'd0, 5'd9, 32'h3018, 32'd0, 5'd9, 5'd0);
        tick();
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        checkOutput("t5_rd9", bus_main.rd1, 32'hAA);
        checkOutput("t5_cnt", bus_main.retire_cnt, 32'd4);
        reset = 1'b1;
        applyStimulus(2'd0, 1'b1, 32'hBB, 32'd0, 5'd9, 32'h301C, 32'd0, 5'd9, 5'd5);
        checkOutput("t5_rst_byp", bus_main.rd1, 32'hBB);
        tick();
        reset = 1'b0;
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd5);
        checkOutput("t5_rd9_after", bus_main.rd1, 32'd0);
        checkOutput("t5_rd5_after", bus_main.rd2, 32'd0);
        checkOutput("t5_cnt_after", bus_main.retire_cnt, 32'd0);
        checkOutput("t5_valid_after", 32'(bus_main.trace_valid), 32'd0);
        checkOutput("t5_data_after", bus_main.trace_data, 32'd0);

        // Sixteen commits wrap the 4-bit counter; last commit at pc8=4 wraps trace_pc
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] pc8_v;
            pc8_v = (i == 16) ? 32'h4 : 32'h1000 + 32'(8 * i);
            applyStimulus(2'd0, 1'b1, 32'(i), 32'd0, 5'(i), pc8_v, 32'd0, 5'd0, 5'd0);
            tick();
            if (i == 15)
                checkOutput("t6_c4_cnt15", 32'(bus_c4.retire_cnt), 32'd15);
        end
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd16, 5'd1);
        checkOutput("t6_c4_wrap", 32'(bus_c4.retire_cnt), 32'd0);
        checkOutput("t6_main_cnt", bus_main.retire_cnt, 32'd16);
        checkOutput("t6_pc_wrap", bus_main.trace_pc, 32'hFFFF_FFFC);
        checkOutput("t6_reg", 32'(bus_main.trace_reg), 32'd16);
        checkOutput("t6_data", bus_main.trace_data, 32'd16);
        checkOutput("t6_rd16", bus_main.rd1, 32'd16);
        checkOutput("t6_rd1", bus_main.rd2, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
